// File: rtl/dtcm_ctrl.sv
// Data-TCM responder: arbitrates core and DMA/debug commands onto one single-port SRAM.
// Define KRV_DTCM_RD_PIPE_EN to add an output register after SRAM rdata (read latency 2).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module dtcm_ctrl #(
  parameter int DTCM_AW      = 14,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic                   data_dtcm_access,
  output logic                   data_dtcm_ready,
  input  logic                   data_dtcm_rd0_wr1,
  input  logic [3:0]             data_dtcm_byte_strobe,
  input  logic [`DATA_WIDTH-1:0] data_dtcm_write_data,
  input  logic [`ADDR_WIDTH-1:0] data_dtcm_addr,
  output logic [`DATA_WIDTH-1:0] data_dtcm_read_data,
  output logic                   data_dtcm_read_data_valid,
  input  logic                   dma_dtcm_req,
  output logic                   dma_dtcm_gnt,
  input  logic                   dma_dtcm_rd0_wr1,
  input  logic [3:0]             dma_dtcm_byte_strobe,
  input  logic [`DATA_WIDTH-1:0] dma_dtcm_wdata,
  input  logic [`ADDR_WIDTH-1:0] dma_dtcm_addr,
  output logic [`DATA_WIDTH-1:0] dma_dtcm_rdata,
  output logic                   dma_dtcm_rdata_valid,
  output logic                   dtcm_ram_cs,
  output logic [3:0]             dtcm_ram_we,
  output logic [DTCM_AW-1:0]     dtcm_ram_addr,
  output logic [`DATA_WIDTH-1:0] dtcm_ram_wdata,
  input  logic [`DATA_WIDTH-1:0] dtcm_ram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  owner_e                 owner_q, owner_d;
  logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic [`DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
  logic [`DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;

  logic core_rd_s;
  logic core_wr_s;
  logic starved_s;
  logic forced_s;
  logic gnt_s;
  logic core_sel_s;
  logic unused_addr_s;

  assign core_rd_s  = data_dtcm_access & ~data_dtcm_rd0_wr1;
  assign core_wr_s  = data_dtcm_access & data_dtcm_rd0_wr1;
  assign starved_s  = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  // A core load is never refused, so even a starved DMA only displaces a store.
  assign forced_s   = dma_dtcm_req & starved_s & ~core_rd_s;
  assign gnt_s      = dma_dtcm_req & ~core_rd_s & (~core_wr_s | starved_s);
  assign core_sel_s = data_dtcm_access & ~gnt_s;

  assign dma_dtcm_gnt    = gnt_s;
  assign data_dtcm_ready = ~forced_s;

  assign unused_addr_s = ^{data_dtcm_addr[`ADDR_WIDTH-1:DTCM_AW+2], data_dtcm_addr[1:0],
                           dma_dtcm_addr[`ADDR_WIDTH-1:DTCM_AW+2], dma_dtcm_addr[1:0]};

  always_comb begin
    dtcm_ram_cs    = 1'b0;
    dtcm_ram_we    = 4'b0000;
    dtcm_ram_addr  = {DTCM_AW{1'b0}};
    dtcm_ram_wdata = {`DATA_WIDTH{1'b0}};
    if (gnt_s) begin
      dtcm_ram_cs    = 1'b1;
      dtcm_ram_we    = dma_dtcm_rd0_wr1 ? dma_dtcm_byte_strobe : 4'b0000;
      dtcm_ram_addr  = dma_dtcm_addr[DTCM_AW+1:2];
      dtcm_ram_wdata = dma_dtcm_wdata;
    end else if (core_sel_s) begin
      dtcm_ram_cs    = 1'b1;
      dtcm_ram_we    = data_dtcm_rd0_wr1 ? data_dtcm_byte_strobe : 4'b0000;
      dtcm_ram_addr  = data_dtcm_addr[DTCM_AW+1:2];
      dtcm_ram_wdata = data_dtcm_write_data;
    end else begin
      dtcm_ram_cs    = 1'b0;
    end
  end

  always_comb begin
    starve_cnt_d = {CNT_W{1'b0}};
    owner_d      = OWN_NONE;
    if (dma_dtcm_req && !gnt_s) begin
      starve_cnt_d = starved_s ? starve_cnt_q : (starve_cnt_q + CNT_W'(1));
    end else begin
      starve_cnt_d = {CNT_W{1'b0}};
    end
    if (core_rd_s) begin
      owner_d = OWN_CORE;
    end else if (gnt_s && !dma_dtcm_rd0_wr1) begin
      owner_d = OWN_DMA;
    end else begin
      owner_d = OWN_NONE;
    end
    // Only the owner of the returning word sees it; the other side keeps its last value.
    core_rdata_d = (owner_q == OWN_CORE) ? dtcm_ram_rdata : core_rdata_q;
    dma_rdata_d  = (owner_q == OWN_DMA)  ? dtcm_ram_rdata : dma_rdata_q;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= {CNT_W{1'b0}};
      core_rdata_q <= {`DATA_WIDTH{1'b0}};
      dma_rdata_q  <= {`DATA_WIDTH{1'b0}};
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

`ifdef KRV_DTCM_RD_PIPE_EN
  owner_e owner_p_q;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      owner_p_q <= OWN_NONE;
    end else begin
      owner_p_q <= owner_q;
    end
  end

  assign data_dtcm_read_data       = core_rdata_q;
  assign data_dtcm_read_data_valid = (owner_p_q == OWN_CORE);
  assign dma_dtcm_rdata            = dma_rdata_q;
  assign dma_dtcm_rdata_valid      = (owner_p_q == OWN_DMA);
`else
  assign data_dtcm_read_data       = core_rdata_d;
  assign data_dtcm_read_data_valid = (owner_q == OWN_CORE);
  assign dma_dtcm_rdata            = dma_rdata_d;
  assign dma_dtcm_rdata_valid      = (owner_q == OWN_DMA);
`endif

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Directed, table-driven bench for dtcm_ctrl with a behavioural byte-writable SRAM.
module tb_dtcm_ctrl;

`ifdef KRV_DTCM_RD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic        c_acc, c_wr, c_rdy, c_val;
  logic [3:0]  c_strb;
  logic [31:0] c_wd, c_addr, c_rd;
  logic        d_req, d_gnt, d_wr, d_val;
  logic [3:0]  d_strb;
  logic [31:0] d_wd, d_addr, d_rd;
  logic        ram_cs;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [0:16383];

  int checks = 0;
  int failures = 0;

  bit          cv_p [0:1];
  logic [31:0] cd_p [0:1];
  bit          dv_p [0:1];
  logic [31:0] dd_p [0:1];
  logic [31:0] last_c = 32'h0;
  logic [31:0] last_d = 32'h0;

  typedef struct {
    logic c_acc, c_wr; logic [3:0] c_strb; logic [31:0] c_wd, c_addr;
    logic d_req, d_wr; logic [3:0] d_strb; logic [31:0] d_wd, d_addr;
    logic e_rdy, e_gnt, e_cs; logic [3:0] e_we; logic [13:0] e_ra; logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [0:13];

  dtcm_ctrl dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .data_dtcm_access(c_acc), .data_dtcm_ready(c_rdy), .data_dtcm_rd0_wr1(c_wr),
    .data_dtcm_byte_strobe(c_strb), .data_dtcm_write_data(c_wd), .data_dtcm_addr(c_addr),
    .data_dtcm_read_data(c_rd), .data_dtcm_read_data_valid(c_val),
    .dma_dtcm_req(d_req), .dma_dtcm_gnt(d_gnt), .dma_dtcm_rd0_wr1(d_wr),
    .dma_dtcm_byte_strobe(d_strb), .dma_dtcm_wdata(d_wd), .dma_dtcm_addr(d_addr),
    .dma_dtcm_rdata(d_rd), .dma_dtcm_rdata_valid(d_val),
    .dtcm_ram_cs(ram_cs), .dtcm_ram_we(ram_we), .dtcm_ram_addr(ram_addr),
    .dtcm_ram_wdata(ram_wdata), .dtcm_ram_rdata(ram_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Single-port SRAM: byte writes, read data one cycle after a cs with we = 0.
  always @(posedge cpu_clk) begin
    if (ram_cs) begin
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  function automatic vec_t mk(logic ca, logic cw, logic [3:0] cs, logic [31:0] cwd, logic [31:0] cad,
                              logic dq, logic dw, logic [3:0] ds, logic [31:0] dwd, logic [31:0] dad,
                              logic rdy, logic gnt, logic ecs, logic [3:0] we, logic [13:0] ra,
                              logic [31:0] rd);
    vec_t v;
    v.c_acc = ca; v.c_wr = cw; v.c_strb = cs; v.c_wd = cwd; v.c_addr = cad;
    v.d_req = dq; v.d_wr = dw; v.d_strb = ds; v.d_wd = dwd; v.d_addr = dad;
    v.e_rdy = rdy; v.e_gnt = gnt; v.e_cs = ecs; v.e_we = we; v.e_ra = ra; v.e_rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge cpu_clk);
    c_acc = v.c_acc; c_wr = v.c_wr; c_strb = v.c_strb; c_wd = v.c_wd; c_addr = v.c_addr;
    d_req = v.d_req; d_wr = v.d_wr; d_strb = v.d_strb; d_wd = v.d_wd; d_addr = v.d_addr;
    #1;
    chk({tag, ".ready"}, {31'b0, c_rdy}, {31'b0, v.e_rdy});
    chk({tag, ".gnt"}, {31'b0, d_gnt}, {31'b0, v.e_gnt});
    chk({tag, ".cs"}, {31'b0, ram_cs}, {31'b0, v.e_cs});
    chk({tag, ".we"}, {28'b0, ram_we}, {28'b0, v.e_we});
    if (v.e_cs) chk({tag, ".ram_addr"}, {18'b0, ram_addr}, {18'b0, v.e_ra});
    if (v.e_we != 4'b0000) chk({tag, ".ram_wdata"}, ram_wdata, v.e_gnt ? v.d_wd : v.c_wd);
    if (cv_p[LAT-1]) last_c = cd_p[LAT-1];
    if (dv_p[LAT-1]) last_d = dd_p[LAT-1];
    chk({tag, ".core_valid"}, {31'b0, c_val}, {31'b0, cv_p[LAT-1]});
    chk({tag, ".core_rdata"}, c_rd, last_c);
    chk({tag, ".dma_valid"}, {31'b0, d_val}, {31'b0, dv_p[LAT-1]});
    chk({tag, ".dma_rdata"}, d_rd, last_d);
    for (int s = LAT - 1; s > 0; s--) begin
      cv_p[s] = cv_p[s-1]; cd_p[s] = cd_p[s-1]; dv_p[s] = dv_p[s-1]; dd_p[s] = dd_p[s-1];
    end
    cv_p[0] = v.c_acc & ~v.c_wr;
    dv_p[0] = v.e_gnt & ~v.d_wr;
    cd_p[0] = v.e_rd;
    dd_p[0] = v.e_rd;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".ready"}, {31'b0, c_rdy}, 32'd1);
    chk({tag, ".gnt"}, {31'b0, d_gnt}, 32'd0);
    chk({tag, ".cs"}, {31'b0, ram_cs}, 32'd0);
    chk({tag, ".we"}, {28'b0, ram_we}, 32'd0);
    chk({tag, ".core_valid"}, {31'b0, c_val}, 32'd0);
    chk({tag, ".dma_valid"}, {31'b0, d_val}, 32'd0);
    chk({tag, ".core_rdata"}, c_rd, 32'd0);
    chk({tag, ".dma_rdata"}, d_rd, 32'd0);
  endtask

  task automatic clear_pipe();
    for (int s = 0; s < 2; s++) begin
      cv_p[s] = 1'b0; dv_p[s] = 1'b0; cd_p[s] = 32'h0; dd_p[s] = 32'h0;
    end
    last_c = 32'h0; last_d = 32'h0;
  endtask

  initial begin
    int idx;
    vec_t v;
    clear_pipe();
    cpu_rstn = 1'b0;
    c_acc = 1'b0; c_wr = 1'b0; c_strb = 4'h0; c_wd = 32'h0; c_addr = 32'h0;
    d_req = 1'b0; d_wr = 1'b0; d_strb = 4'h0; d_wd = 32'h0; d_addr = 32'h0;

    //                 core: acc wr strb  wdata          addr           dma: req wr strb  wdata          addr           rdy  gnt  cs   we     ra      rd
    vecs[0]  = mk(1'b1, 1'b1, 4'hF, 32'h12345678, 32'h00000010, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 4'hF, 14'h4, 32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 4'hF, 32'h0,        32'h00000010, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 4'h0, 14'h4, 32'h12345678);
    vecs[2]  = mk(1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    vecs[3]  = mk(1'b1, 1'b1, 4'h8, 32'hAB000000, 32'h00000010, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 4'h8, 14'h4, 32'h0);
    vecs[4]  = mk(1'b1, 1'b0, 4'hF, 32'h0,        32'h00000010, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 4'h0, 14'h4, 32'hAB345678);
    vecs[5]  = mk(1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 32'h00000020, 1'b1, 1'b1, 1'b1, 4'hF, 14'h8, 32'h0);
    vecs[6]  = mk(1'b1, 1'b0, 4'hF, 32'h0,        32'h00000010, 1'b1, 1'b0, 4'h0, 32'h0,        32'h00000020, 1'b1, 1'b0, 1'b1, 4'h0, 14'h4, 32'hAB345678);
    vecs[7]  = mk(1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 4'h0, 32'h0,        32'h00000020, 1'b1, 1'b1, 1'b1, 4'h0, 14'h8, 32'hCAFEF00D);
    vecs[8]  = mk(1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 4'h0, 32'h0,        32'h00000020, 1'b1, 1'b1, 1'b1, 4'h0, 14'h8, 32'hCAFEF00D);
    vecs[9]  = mk(1'b1, 1'b0, 4'hF, 32'h0,        32'hFFFF0013, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 4'h0, 14'h4, 32'hAB345678);
    vecs[10] = mk(1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 4'h1, 32'h000000EE, 32'h00000022, 1'b1, 1'b1, 1'b1, 4'h1, 14'h8, 32'h0);
    vecs[11] = mk(1'b1, 1'b0, 4'hF, 32'h0,        32'h00000020, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 4'h0, 14'h8, 32'hCAFEF0EE);
    vecs[12] = mk(1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    vecs[13] = vecs[12];

    repeat (2) @(negedge cpu_clk);
    #1;
    chk_reset_outs("reset");
    cpu_rstn = 1'b1;

    for (int i = 0; i < 14; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Starvation by back-to-back stores: DMA forced on the ninth cycle, store repeats next.
    idx = 0;
    for (int n = 1; n <= 12; n++) begin
      v = mk(1'b1, 1'b1, 4'hF, 32'h1000 + 32'(idx), 32'h40 + 32'(4 * idx),
             (n <= 9), 1'b1, 4'hF, 32'h5A5A5A5A, 32'h80,
             (n != 9), (n == 9), 1'b1, 4'hF, (n == 9) ? 14'h20 : 14'(16 + idx), 32'h0);
      apply(v, $sformatf("starve%0d", n));
      if (n != 9) idx++;
    end
    apply(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b1, 4'h0, 14'h20, 32'h5A5A5A5A), "starve_rd_dma");
    apply(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h60, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b1, 4'h0, 14'h18, 32'h00001008), "starve_rd_held");

    // A core load beats a DMA already at the starvation limit.
    for (int n = 1; n <= 8; n++)
      apply(mk(1'b1, 1'b1, 4'hF, 32'h2000 + 32'(n), 32'h100 + 32'(4 * n), 1'b1, 1'b0, 4'h0, 32'h0, 32'h20,
               1'b1, 1'b0, 1'b1, 4'hF, 14'(64 + n), 32'h0), $sformatf("ld_beats%0d", n));
    apply(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h10, 1'b1, 1'b0, 4'h0, 32'h0, 32'h20,
             1'b1, 1'b0, 1'b1, 4'h0, 14'h4, 32'hAB345678), "ld_beats_load");
    apply(mk(1'b1, 1'b1, 4'hF, 32'h200A, 32'h128, 1'b1, 1'b0, 4'h0, 32'h0, 32'h20,
             1'b0, 1'b1, 1'b1, 4'h0, 14'h8, 32'hCAFEF0EE), "ld_beats_forced");
    apply(mk(1'b1, 1'b1, 4'hF, 32'h200A, 32'h128, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b1, 4'hF, 14'h4A, 32'h0), "ld_beats_store");

    // Dropping the request for one cycle restarts the starvation count.
    idx = 0;
    for (int n = 1; n <= 16; n++) begin
      v = mk(1'b1, 1'b1, 4'hF, 32'h3000 + 32'(idx), 32'h200 + 32'(4 * idx),
             (n != 6) && (n <= 15), 1'b1, 4'hF, 32'h00000033, 32'h84,
             (n != 15), (n == 15), 1'b1, 4'hF, (n == 15) ? 14'h21 : 14'(128 + idx), 32'h0);
      apply(v, $sformatf("clear%0d", n));
      if (n != 15) idx++;
    end

    // Reset arriving right after a load is accepted drops the pending return.
    apply(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b1, 4'h0, 14'h4, 32'hAB345678), "rst_rd");
    @(posedge cpu_clk);
    #1;
    cpu_rstn = 1'b0;
    c_acc = 1'b0;
    @(negedge cpu_clk);
    #1;
    chk_reset_outs("midrst");
    clear_pipe();
    cpu_rstn = 1'b1;
    apply(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h84, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
             1'b1, 1'b0, 1'b1, 4'h0, 14'h21, 32'h00000033), "post_rst_rd");
    apply(vecs[12], "drain0");
    apply(vecs[12], "drain1");
    apply(vecs[12], "drain2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dtcm_ctrl.md
Name: dtcm_ctrl

Overview:
- Responder side of the core data-TCM interface. Accepts load/store commands from the core data-memory controller and an auxiliary DMA/debug port.
- Arbitrates between the two, drives a single-port synchronous SRAM macro, and returns read data with a fixed latency and a valid strobe.
- Sits between the core MEM stage and the DTCM SRAM instance inside the core top.

Parameters:
- DTCM_AW, 14, SRAM word-address width (2^DTCM_AW words of 32 bits; 64 KB default).
- STARVE_LIMIT, 8, consecutive cycles a pending DMA request may be refused before it is forced through.
- CNT_W, 4, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- cpu_clk  input  1  cpu clock
- cpu_rstn  input  1  cpu reset, asynchronous, active low
- data_dtcm_access  input  1  core command strobe, single-cycle for loads, held for stores until ready
- data_dtcm_ready  output  1  core store may complete this cycle
- data_dtcm_rd0_wr1  input  1  core command, 0 = read, 1 = write
- data_dtcm_byte_strobe  input  4  core byte lanes
- data_dtcm_write_data  input  `DATA_WIDTH  core write data, already lane-aligned
- data_dtcm_addr  input  `ADDR_WIDTH  byte offset from DTCM base
- data_dtcm_read_data  output  `DATA_WIDTH  core read data, full word
- data_dtcm_read_data_valid  output  1  core read data valid, one cycle
- dma_dtcm_req  input  1  DMA request, held until granted
- dma_dtcm_gnt  output  1  DMA request accepted this cycle
- dma_dtcm_rd0_wr1  input  1  DMA command
- dma_dtcm_byte_strobe  input  4  DMA byte lanes
- dma_dtcm_wdata  input  `DATA_WIDTH  DMA write data
- dma_dtcm_addr  input  `ADDR_WIDTH  DMA byte offset
- dma_dtcm_rdata  output  `DATA_WIDTH  DMA read data
- dma_dtcm_rdata_valid  output  1  DMA read data valid, one cycle
- dtcm_ram_cs  output  1  SRAM chip select
- dtcm_ram_we  output  4  SRAM per-byte write enable
- dtcm_ram_addr  output  DTCM_AW  SRAM word address
- dtcm_ram_wdata  output  `DATA_WIDTH  SRAM write data
- dtcm_ram_rdata  input  `DATA_WIDTH  SRAM read data, valid one cycle after cs with we = 0

Behaviour:
- Reset values:
  - all valids, gnt and cs = 0; we = 0.
  - read data outputs = 0; data_dtcm_ready = 1.
  - starvation counter = 0; read-owner register = NONE.
- SRAM word address is addr[DTCM_AW+1:2]. Byte offset bits [1:0] and upper bits are ignored; no alignment checking.
- Core loads are always accepted in the cycle presented, because the core never repeats a load strobe. A core load beats any DMA request, including a forced one.
- Core store vs DMA, normal case: the core store wins, and DMA waits.
- Core store vs DMA, forced case: when the starvation counter reaches STARVE_LIMIT and dma_dtcm_req = 1 with no core load this cycle, DMA is granted and data_dtcm_ready = 0. The core holds the store and completes it next cycle.
- data_dtcm_ready is combinational and drops only in that forced-DMA cycle.
- DMA is granted whenever there is no core access, or in the forced case above.
- Starvation counter:
  - increments while dma_dtcm_req = 1 and not granted, saturating at STARVE_LIMIT;
  - clears on grant or when req = 0.
- SRAM drive in a selected cycle: cs = 1, we = strobe if write else 0, wdata/addr from the winner. Write completes in that cycle.
- Read-owner register is set to CORE or DMA on an accepted read, otherwise NONE.
- Read return, next cycle:
  - the owner's valid = 1 and its read data = dtcm_ram_rdata, full word; the core performs lane extraction.
  - the non-owner's read data is held at its last value.
- Read latency is 1 cycle. Back-to-back reads are sustainable at one per cycle.
- Simultaneous core store and core load cannot occur: the core issues one command at a time.
- Reset mid-read: the pending valid is discarded and the owner returns to NONE.

Optional Feature:
- Macro: KRV_DTCM_RD_PIPE_EN.
- When defined: an output register stage is added after SRAM rdata. Read latency becomes 2 cycles, valid and data are both delayed one cycle, and the owner is tracked through a 2-deep pipe. Back-to-back throughput is unchanged.
- When not defined: latency is 1 cycle, as described above.

Test Plan:
- Core write 0x12345678 strobe 4'b1111 at offset 0x10, then core read at 0x10 -> ram_we = 4'hF in cycle 0; data_dtcm_read_data = 0x12345678 with valid high exactly 1 cycle after the read (2 cycles with KRV_DTCM_RD_PIPE_EN).
- Core byte write 0xAB00_0000 strobe 4'b1000 at offset 0x10 over 0x12345678, then read -> ram_we = 4'b1000; read returns 0xAB345678.
- Core load and dma_dtcm_req in the same cycle -> core read executed, dma_dtcm_gnt = 0, counter = 1; DMA granted next idle cycle.
- Continuous core stores for 12 cycles with DMA req held -> gnt asserted in cycle 9 (counter = 8) and data_dtcm_ready = 0 in that cycle only; core store completes in cycle 10; counter clears.
- Interleaved DMA read at offset 0x20 then core read at 0x10 on consecutive cycles -> dma_dtcm_rdata_valid then data_dtcm_read_data_valid on consecutive cycles, each with the correct word; no cross-delivery.
- Assert cpu_rstn low the cycle after a core read is accepted -> no valid emitted; all outputs at reset values; next read after reset returns correctly.
